// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-AEAD128 sequencer.
// ASCON_CTRL_UNROLL2_EN selects two permutation rounds per cycle.
package ascon_pkg;

    localparam int RND_LAST     = 11;
    localparam int RND_IDX_W    = 4;
    localparam int ROUNDS_A_DEF = 12;
    localparam int ROUNDS_B_DEF = 8;

`ifdef ASCON_CTRL_UNROLL2_EN
    localparam int RND_STEP = 2;
`else
    localparam int RND_STEP = 1;
`endif

    // Counter value of the final cycle of a permutation run.
    localparam int RND_EXIT = RND_LAST + 1 - RND_STEP;

    typedef enum logic [2:0] {
        SEL_INIT   = 3'd0,
        SEL_ROUND  = 3'd1,
        SEL_ABSORB = 3'd2,
        SEL_KEY_LO = 3'd3,
        SEL_DOMSEP = 3'd4,
        SEL_KEY_HI = 3'd5
    } st_sel_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_INIT_KEY,
        S_AD_WAIT,
        S_AD_PERM,
        S_DOMSEP,
        S_DATA_WAIT,
        S_DATA_PERM,
        S_FINAL_KEY,
        S_FINAL_PERM,
        S_TAG
    } ctrl_state_t;

    function automatic logic [RND_IDX_W-1:0] rnd_start(input int rounds);
        return RND_IDX_W'(RND_LAST + 1 - rounds);
    endfunction

endpackage

// File: rtl/ascon_round_cnt.sv
// Loadable round counter; done flags the last cycle of a permutation run.
// Steps by 2 when ASCON_CTRL_UNROLL2_EN is defined.
module ascon_round_cnt
    import ascon_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [RND_IDX_W-1:0] load_val,
    input  logic                 step,
    output logic [RND_IDX_W-1:0] cnt,
    output logic                 done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            cnt <= cnt + RND_IDX_W'(RND_STEP);
        end
    end

    assign done = (cnt == RND_IDX_W'(RND_EXIT));

endmodule

// File: rtl/ascon_ctrl.sv
// Ascon-AEAD128 sequencer: drives state enable/select and round index, one round per cycle
// (two with ASCON_CTRL_UNROLL2_EN); blk_ready/dout_en/tag_valid are same-cycle decodes.
module ascon_ctrl
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A = ROUNDS_A_DEF,
    parameter int ROUNDS_B = ROUNDS_B_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 decrypt,
    input  logic                 has_ad,
    output logic                 busy,
    input  logic                 blk_valid,
    input  logic                 blk_last,
    output logic                 blk_ready,
    output logic                 blk_is_ad,
    output logic                 dout_en,
    output logic                 st_en,
    output st_sel_t              st_sel,
    output logic [RND_IDX_W-1:0] rnd_idx,
    output logic                 mode_dec,
    output logic                 tag_valid,
    input  logic                 tag_ready
);

    if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
        $error("ascon_ctrl: ROUNDS_A must be in 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
        $error("ascon_ctrl: ROUNDS_B must be in 1..12");
    end
`ifdef ASCON_CTRL_UNROLL2_EN
    if ((ROUNDS_A % 2) != 0 || (ROUNDS_B % 2) != 0) begin : g_bad_unroll
        $error("ascon_ctrl: ROUNDS_A and ROUNDS_B must be even when unrolled by 2");
    end
`endif

    localparam logic [RND_IDX_W-1:0] A_START = rnd_start(ROUNDS_A);
    localparam logic [RND_IDX_W-1:0] B_START = rnd_start(ROUNDS_B);

    ctrl_state_t          state;
    logic                 busy_q;
    logic                 dec_q;
    logic                 ad_q;
    logic                 last_q;
    logic                 is_ad_q;

    logic                 en_c;
    st_sel_t              sel_c;
    logic                 cnt_load;
    logic [RND_IDX_W-1:0] cnt_val;
    logic                 cnt_step;
    logic [RND_IDX_W-1:0] rnd_cnt;
    logic                 rnd_done;
    logic                 in_perm;
    logic                 in_wait;

    ascon_round_cnt u_round_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .step     (cnt_step),
        .cnt      (rnd_cnt),
        .done     (rnd_done)
    );

    assign in_perm = (state == S_INIT) || (state == S_AD_PERM) ||
                     (state == S_DATA_PERM) || (state == S_FINAL_PERM);
    assign in_wait = (state == S_AD_WAIT) || (state == S_DATA_WAIT);

    always_comb begin
        en_c     = 1'b0;
        sel_c    = SEL_INIT;
        cnt_load = 1'b0;
        cnt_val  = A_START;
        cnt_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    en_c     = 1'b1;
                    sel_c    = SEL_INIT;
                    cnt_load = 1'b1;
                    cnt_val  = A_START;
                end
            end
            S_INIT, S_AD_PERM, S_DATA_PERM, S_FINAL_PERM: begin
                en_c     = 1'b1;
                sel_c    = SEL_ROUND;
                cnt_step = 1'b1;
            end
            S_INIT_KEY: begin
                en_c  = 1'b1;
                sel_c = SEL_KEY_LO;
            end
            S_AD_WAIT: begin
                if (blk_valid) begin
                    en_c     = 1'b1;
                    sel_c    = SEL_ABSORB;
                    cnt_load = 1'b1;
                    cnt_val  = B_START;
                end
            end
            S_DOMSEP: begin
                en_c  = 1'b1;
                sel_c = SEL_DOMSEP;
            end
            S_DATA_WAIT: begin
                if (blk_valid) begin
                    en_c     = 1'b1;
                    sel_c    = SEL_ABSORB;
                    cnt_load = !blk_last;
                    cnt_val  = B_START;
                end
            end
            S_FINAL_KEY: begin
                en_c     = 1'b1;
                sel_c    = SEL_KEY_HI;
                cnt_load = 1'b1;
                cnt_val  = A_START;
            end
            default: ;
        endcase
    end

    // A reset cycle must never write the state, even mid-permutation.
    assign st_en     = en_c && !rst;
    assign st_sel    = st_en ? sel_c : SEL_INIT;
    assign rnd_idx   = in_perm ? rnd_cnt : '0;
    assign blk_ready = in_wait && !rst;
    assign dout_en   = (state == S_DATA_WAIT) && blk_valid && !rst;
    assign tag_valid = (state == S_TAG) && !rst;
    assign busy      = busy_q;
    assign mode_dec  = dec_q;
    assign blk_is_ad = is_ad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            dec_q   <= 1'b0;
            ad_q    <= 1'b0;
            last_q  <= 1'b0;
            is_ad_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_INIT;
                        busy_q <= 1'b1;
                        dec_q  <= decrypt;
                        ad_q   <= has_ad;
                    end
                end
                S_INIT: begin
                    if (rnd_done) state <= S_INIT_KEY;
                end
                S_INIT_KEY: begin
                    if (ad_q) begin
                        state   <= S_AD_WAIT;
                        is_ad_q <= 1'b1;
                    end else begin
                        state <= S_DOMSEP;
                    end
                end
                S_AD_WAIT: begin
                    if (blk_valid) begin
                        state  <= S_AD_PERM;
                        last_q <= blk_last;
                    end
                end
                S_AD_PERM: begin
                    if (rnd_done) state <= last_q ? S_DOMSEP : S_AD_WAIT;
                end
                S_DOMSEP: begin
                    state   <= S_DATA_WAIT;
                    is_ad_q <= 1'b0;
                end
                S_DATA_WAIT: begin
                    if (blk_valid) state <= blk_last ? S_FINAL_KEY : S_DATA_PERM;
                end
                S_DATA_PERM: begin
                    if (rnd_done) state <= S_DATA_WAIT;
                end
                S_FINAL_KEY: begin
                    state <= S_FINAL_PERM;
                end
                S_FINAL_PERM: begin
                    if (rnd_done) state <= S_TAG;
                end
                S_TAG: begin
                    // Any start seen here is dropped; it is honoured from the next IDLE cycle.
                    if (tag_ready) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        dec_q  <= 1'b0;
                        ad_q   <= 1'b0;
                        last_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
